// File: rtl/par_pkg.sv
// Shared definitions for the parity receive path: FSM state type, parity
// sense and the parity calculation used by both generator and checker.
// Build option: define PAR_CHECK_ODD_EN to switch the check to odd parity.
package par_pkg;

  // state  | meaning
  // IDLE   | line idle, waiting for rxd_s low
  // START  | qualifying start bit at its mid-point
  // DATA   | sampling DATA_W data bits, LSB first
  // PARITY | sampling the parity bit
  // STOP   | sampling the stop bit, then publishing the frame
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } par_rx_state_t;

`ifdef PAR_CHECK_ODD_EN
  localparam bit PAR_ODD = 1'b1;
`else
  localparam bit PAR_ODD = 1'b0;
`endif

  // Widest supported data word; narrower words are zero-extended, which
  // leaves the parity unchanged.
  localparam int PAR_CALC_W = 32;

  // With p=0 this is the parity bit to transmit; with the received p it is
  // the mismatch flag (1 = parity error).
  function automatic logic par_calc(input logic [PAR_CALC_W-1:0] data,
                                    input logic                  p);
    return (^{data, p}) ^ PAR_ODD;
  endfunction

endpackage

// File: rtl/par_baud_tick.sv
// Bit-period timer for the serial receiver. Counts clk cycles within a bit
// and strobes tick at the half-bit or full-bit point, restarting afterwards.
module par_baud_tick #(
  parameter int BAUD_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic half,
  output logic tick
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BAUD_DIV / 2 - 1);

  logic [CNT_W-1:0] cnt;

  // Strobe on the selected terminal count; suppressed while held clear.
  assign tick = ~clear && (cnt == (half ? HALF_CNT : FULL_CNT));

  // Cycle counter: held at 0 while clear, wraps to 0 on each strobe so the
  // next sample lands exactly one bit period later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/par_check_rx.sv
// Serial receiver with parity and framing check. Frames are start(0),
// DATA_W data bits LSB first, parity, stop(1). Completed frames are held on
// a valid/ready interface; an unconsumed frame is overwritten and flagged.
// Build option: PAR_CHECK_ODD_EN selects odd parity (see par_pkg).
module par_check_rx
  import par_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int BAUD_DIV = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  output logic [DATA_W-1:0] dout,
  output logic              par_err,
  output logic              frame_err,
  output logic              ovr,
  output logic              valid,
  input  logic              ready
);

  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] DATA_MSB = DATA_W'(1) << (DATA_W - 1);

  logic              rxd_m;
  logic              rxd_s;
  par_rx_state_t     state;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;
  logic              par_bit;
  logic              tick;
  logic              tmr_clear;
  logic              tmr_half;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // Timer is parked in IDLE so START begins counting from 0 at the edge
  // detect; only START uses the half-bit point, everything after is full-bit.
  assign tmr_clear = (state == IDLE);
  assign tmr_half  = (state == START);

  par_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(tmr_clear),
    .half (tmr_half),
    .tick (tick)
  );

  // Receive FSM plus output holding register and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      idx       <= '0;
      par_bit   <= 1'b0;
      dout      <= '0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
      ovr       <= 1'b0;
      valid     <= 1'b0;
    end else begin
      // Consumption; a completion in the same cycle overrides this below.
      if (valid && ready) begin
        valid <= 1'b0;
        ovr   <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state <= START;
          end
        end

        START: begin
          if (tick) begin
            if (rxd_s) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              idx   <= '0;
            end
          end
        end

        DATA: begin
          if (tick) begin
            // Shift in from the top so the first bit ends up in bit 0.
            shreg <= (shreg >> 1) | (rxd_s ? DATA_MSB : '0);
            if (idx == LAST_IDX) begin
              state <= PARITY;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        PARITY: begin
          if (tick) begin
            par_bit <= rxd_s;
            state   <= STOP;
          end
        end

        STOP: begin
          if (tick) begin
            // A bad stop bit is reported but never stalls reception.
            dout      <= shreg;
            par_err   <= par_calc(PAR_CALC_W'(shreg), par_bit);
            frame_err <= ~rxd_s;
            valid     <= 1'b1;
            ovr       <= valid && !ready;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_par_check_rx.sv
// Directed plus randomized bench for par_check_rx (DATA_W=8, BAUD_DIV=16).
// Frames are driven bit by bit on rxd; a frame-level model predicts the
// output register contents, flags and handshake state.
module tb_par_check_rx;

  localparam int DATA_W = 8;
  localparam int BAUD   = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rxd;
  logic              ready;
  logic [DATA_W-1:0] dout;
  logic              par_err;
  logic              frame_err;
  logic              ovr;
  logic              valid;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] m_dout  = '0;
  logic              m_par   = 1'b0;
  logic              m_fe    = 1'b0;
  logic              m_ovr   = 1'b0;
  logic              m_valid = 1'b0;

  always #5 clk = ~clk;

  par_check_rx #(
    .DATA_W  (DATA_W),
    .BAUD_DIV(BAUD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .dout     (dout),
    .par_err  (par_err),
    .frame_err(frame_err),
    .ovr      (ovr),
    .valid    (valid),
    .ready    (ready)
  );

  function automatic logic exp_par(input logic [DATA_W-1:0] d, input logic p);
    int ones;
    ones = $countones(d) + int'(p);
`ifdef PAR_CHECK_ODD_EN
    return (ones % 2) == 0;
`else
    return (ones % 2) == 1;
`endif
  endfunction

  task automatic chk1(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk1({tag, ".valid"},     32'(valid),     32'(m_valid));
    chk1({tag, ".ovr"},       32'(ovr),       32'(m_ovr));
    chk1({tag, ".dout"},      32'(dout),      32'(m_dout));
    chk1({tag, ".par_err"},   32'(par_err),   32'(m_par));
    chk1({tag, ".frame_err"}, 32'(frame_err), 32'(m_fe));
  endtask

  // Drive one full frame; optionally check that valid rises exactly one
  // clock after the stop-bit mid-sample (only meaningful from valid=0).
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p,
                            input logic s, input logic chk_lat);
    logic [DATA_W+2:0] bits;
    int k;
    bits = {s, p, d, 1'b0};
    k = 0;
    for (int b = 0; b < DATA_W + 3; b++) begin
      rxd = bits[b];
      repeat (BAUD) begin
        @(negedge clk);
        k++;
        if (chk_lat && k == 170) chk1("lat_before", 32'(valid), 32'd0);
        if (chk_lat && k == 171) chk1("lat_after",  32'(valid), 32'd1);
      end
    end
    rxd = 1'b1;
    m_ovr   = m_valid;
    m_valid = 1'b1;
    m_dout  = d;
    m_par   = exp_par(d, p);
    m_fe    = !s;
  endtask

  task automatic consume(input string tag);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    logic              rp;
    logic              rs;

    rst_n = 1'b0;
    rxd   = 1'b1;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    idle(5);

    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    check_all("a5_p0");
    consume("a5_p0_take");

    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    check_all("a5_p1");
    consume("a5_p1_take");

    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    check_all("01_p1");
    consume("01_p1_take");

    // Low stop bit: the still-low line causes a false start, so leave a gap.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    check_all("3c_stop0");
    consume("3c_take");
    idle(40);
    send_frame(8'h55, 1'b0, 1'b1, 1'b1);
    check_all("55_after_ferr");
    consume("55_take");

    // Glitch shorter than half a bit.
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    check_all("false_start");
    send_frame(8'h96, 1'b0, 1'b1, 1'b1);
    check_all("96_after_false");
    consume("96_take");

    // Overwrite with ready held low.
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);
    check_all("ovr_first");
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    check_all("ovr_second");
    consume("ovr_take");

    // Reset in the middle of the data bits of 0x77, with a frame pending.
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    check_all("pre_rst");
    rxd = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      rxd = 1'b1;
      repeat (BAUD) @(negedge clk);
    end
    rxd = 1'b0;
    repeat (BAUD / 2) @(negedge clk);
    rst_n = 1'b0;
    rxd   = 1'b1;
    #1;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_dout  = '0;
    m_par   = 1'b0;
    m_fe    = 1'b0;
    check_all("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    idle(200);
    check_all("rst_no_frame");
    send_frame(8'h0F, 1'b0, 1'b1, 1'b1);
    check_all("0f_after_rst");
    consume("0f_take");

    // Random frames, random parity/stop, random consumption.
    for (int i = 0; i < 12; i++) begin
      rd = DATA_W'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rd, rp, rs, !m_valid);
      check_all("rand");
      if ($urandom_range(0, 1) == 1) consume("rand_take");
      if (!rs) idle(40);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/par_check_rx.md
Name: par_check_rx

Overview:
- Serial receiver and parity checker; the receive-side counterpart of the team's even-parity generator.
- Deserializes frames of the form: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1).
- Checks parity and framing, then presents the word plus error flags on a valid/ready output interface.
- Sits between the serial pin (rxd) and downstream consumer logic.

Parameters:
DATA_W, 8, data bits per frame (1..32)
BAUD_DIV, 16, clk cycles per serial bit (>=4)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rxd  in  1  serial input, idle high, asynchronous to clk
dout  out  DATA_W  received data word
par_err  out  1  parity mismatch for the frame on dout
frame_err  out  1  stop bit sampled as 0 for the frame on dout
ovr  out  1  previous unconsumed frame was overwritten
valid  out  1  dout and flags hold an unconsumed frame
ready  in  1  consumer accepts when valid && ready

Behaviour:
- Reset: clk is a single clock; rst_n is asynchronous, active-low. While rst_n=0, all outputs are 0, the FSM is in IDLE and the counters are 0. An in-flight frame is discarded. The synchronizer resets to 1.
- Input sync: rxd passes through a 2-flop synchronizer (rxd_s). All sampling uses rxd_s.
- Bit counter: cnt counts 0..BAUD_DIV-1. Width is clog2(BAUD_DIV). Bit index width is clog2(DATA_W+1).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on rxd_s=0, go to START with cnt=0.
  - START: at cnt=BAUD_DIV/2-1, sample rxd_s.
    - If 1: false start; return to IDLE with no output.
    - If 0: clear cnt and go to DATA with idx=0. All later samples therefore fall at bit mid-points.
  - DATA: at cnt=BAUD_DIV-1, shift rxd_s into bit idx (LSB first) and increment idx. After DATA_W bits, go to PARITY.
  - PARITY: at cnt=BAUD_DIV-1, capture bit p, then go to STOP.
  - STOP: at cnt=BAUD_DIV-1, sample stop bit s and complete the frame. Go to IDLE.
    - A low stop bit does not stall the FSM.
    - If rxd_s is still 0 in IDLE, a new start is detected; this is accepted behaviour.
- Parity rule: even parity. par_err = ^{data, p}, i.e. 1 when the total count of ones is odd.
- Frame completion: one cycle after the STOP sample, the following are registered together:
  - dout
  - par_err
  - frame_err = ~s
  - valid = 1
- Output handshake:
  - valid stays high until a cycle with valid && ready, then clears on the next edge.
  - dout and flags are stable while valid=1, except on overwrite.
- Overwrite (completion while valid=1 and ready=0): dout and flags are replaced with the new frame, ovr=1, valid stays 1.
- Completion with valid && ready in the same cycle: the old frame is consumed, the new one is loaded, valid stays 1, ovr=0.
- ovr is cleared with the frame on handshake.
- Throughput: one frame per (DATA_W+3)*BAUD_DIV cycles, minus half a bit. Back-to-back frames must be received without loss.

Optional Feature:
- Macro: PAR_CHECK_ODD_EN.
- Defined: odd parity. par_err = ~^{data, p}.
- Undefined: even parity as above, matching the team's generator.
- No port or timing change in either case.

Decomposition:
- Package par_pkg holds:
  - the state enum par_rx_state_t (IDLE, START, DATA, PARITY, STOP)
  - the constant PAR_ODD (0/1), derived from PAR_CHECK_ODD_EN
  - a function par_calc(data, p) shared with the generator side.
- One natural sub-module: par_baud_tick. It contains cnt, takes clear/half-bit selection, and emits a sample strobe. The FSM and output register stay in par_check_rx.

Test Plan:
- DATA_W=8, BAUD_DIV=16: send 0xA5, p=0, stop=1 -> valid=1 with dout=0xA5, par_err=0, frame_err=0, ovr=0. Latency is 1 clk after the stop mid-sample.
- Send 0xA5 with p=1 -> dout=0xA5, par_err=1. Send 0x01 with p=1 -> par_err=0. With PAR_CHECK_ODD_EN defined, both results invert.
- Send 0x3C, p=0, stop=0 -> frame_err=1, par_err=0. Next frame 0x55 (p=0) is received correctly.
- Hold rxd low for 4 clk, then high -> false start. valid stays 0 and the FSM returns to IDLE.
- ready=0, send 0x11 then 0x22 back-to-back -> dout=0x22, ovr=1. Assert ready for 1 cycle -> valid=0, ovr=0 on the next edge.
- Drop rst_n for 1 cycle mid-DATA of frame 0x77 -> all outputs 0 immediately and no frame is delivered. The following frame 0x0F (p=0) is received correctly.
